fdivsqrt_issue_ctrl: RTL

//   Requester-side sequencer for the FP divide/square-root unit. Accepts one div/sqrt op

---
 rtl/fdivsqrt_issue_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/fdivsqrt_issue_ctrl.sv
// Requester-side sequencer for the FP divide/sqrt unit: holds one op, issues it to the unit,
// waits for its finish pulse and returns the captured result and flags to writeback.
module fdivsqrt_issue_ctrl #(
  parameter int EXPWIDTH = 11,
  parameter int SIGWIDTH = 53,
  parameter int TAGWIDTH = 5,
  parameter int TININESS = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [EXPWIDTH+SIGWIDTH-1:0] req_frs1,
  input  logic [EXPWIDTH+SIGWIDTH-1:0] req_frs2,
  input  logic                         req_sqrt,
  input  logic [2:0]                   req_rm,
  input  logic [TAGWIDTH-1:0]          req_tag,
  input  logic                         flush,
  output logic                         du_valid_in,
  input  logic                         du_ready_out,
  output logic [EXPWIDTH+SIGWIDTH-1:0] du_frs1,
  output logic [EXPWIDTH+SIGWIDTH-1:0] du_frs2,
  output logic                         du_ftype,
  output logic                         du_fcontrol,
  output logic [2:0]                   du_rm,
  input  logic                         du_finish,
  input  logic [EXPWIDTH+SIGWIDTH-1:0] du_res,
  input  logic [4:0]                   du_flags,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [EXPWIDTH+SIGWIDTH-1:0] resp_res,
  output logic [4:0]                   resp_flags,
  output logic [TAGWIDTH-1:0]          resp_tag,
  output logic                         busy
);

  localparam int W = EXPWIDTH + SIGWIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DRAIN,
    S_RESP
  } state_t;

  state_t              state_reg, state_next;
  logic [W-1:0]        frs1_reg, frs2_reg, res_reg;
  logic                sqrt_reg;
  logic [2:0]          rm_reg;
  logic [TAGWIDTH-1:0] tag_reg;
  logic [4:0]          flags_reg;
  logic                latch_req, capture_res;

  always_comb begin
    state_next  = state_reg;
    latch_req   = 1'b0;
    capture_res = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (req_valid && !flush) begin
          latch_req  = 1'b1;
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (flush)             state_next = S_IDLE;
        else if (du_ready_out) state_next = S_WAIT;
      end
      S_WAIT: begin
        // The unit cannot abort, so a flushed op must still have its finish swallowed.
        if (flush) begin
          state_next = du_finish ? S_IDLE : S_DRAIN;
        end else if (du_finish) begin
          capture_res = 1'b1;
          state_next  = S_RESP;
        end
      end
      S_DRAIN: begin
        if (du_finish) state_next = S_IDLE;
      end
      S_RESP: begin
        if (flush || resp_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      frs1_reg  <= '0;
      frs2_reg  <= '0;
      sqrt_reg  <= 1'b0;
      rm_reg    <= '0;
      tag_reg   <= '0;
      res_reg   <= '0;
      flags_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (latch_req) begin
        frs1_reg <= req_frs1;
        frs2_reg <= req_frs2;
        sqrt_reg <= req_sqrt;
        rm_reg   <= req_rm;
        tag_reg  <= req_tag;
      end
      if (capture_res) begin
        res_reg   <= du_res;
        flags_reg <= du_flags;
      end
    end
  end

  assign req_ready   = (state_reg == S_IDLE);
  assign busy        = (state_reg != S_IDLE);
  assign du_valid_in = (state_reg == S_ISSUE) && !flush;
  assign du_frs1     = frs1_reg;
  assign du_frs2     = frs2_reg;
  assign du_ftype    = sqrt_reg;
  assign du_rm       = rm_reg;
  assign du_fcontrol = (TININESS != 0);
  assign resp_valid  = (state_reg == S_RESP);
  assign resp_res    = res_reg;
  assign resp_flags  = flags_reg;
  assign resp_tag    = tag_reg;

endmodule
